// File: rtl/data_pipe_demux.sv
`default_nettype none
// ============================================================================
// Module      : data_pipe_demux
// Description : A 2-entry elastic buffer sitting between one valid/ready
//               upstream port (s00) and eight valid/ready downstream ports
//               (m00..m07). Words leave on the path that was active when
//               they were accepted. The active path may change only while
//               the buffer is empty and no word is entering it.
//               Port groups are flattened: index NN of m_valid / m_ready /
//               m_data corresponds to downstream port mNN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_pipe_demux #(
    parameter int DSIZE = 8
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic                        vld_sw,
    input  logic [2:0]                  sw,
    output logic [2:0]                  curr_path,
    // upstream (s00)
    input  logic                        s00_valid,
    output logic                        s00_ready,
    input  logic [DSIZE-1:0]            s00_data,
    // downstream (m00..m07)
    output logic [7:0]                  m_valid,
    input  logic [7:0]                  m_ready,
    output logic [7:0][DSIZE-1:0]       m_data
);

    // Occupancy of the buffer doubles as the controller state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         path_q;
    logic [DSIZE-1:0]   head_q;   // oldest stored word, presented downstream
    logic [DSIZE-1:0]   tail_q;   // second word, valid only when FULL

    logic               acc;      // upstream transfer this cycle
    logic               del;      // downstream transfer this cycle

    // Ready never looks at downstream, so a full buffer simply stalls upstream.
    assign s00_ready = vld_sw && (state_q != FULL);
    assign acc       = s00_valid && s00_ready && clk_en;
    assign del       = (state_q != EMPTY) && m_ready[path_q] && clk_en;
    assign curr_path = path_q;

    // Occupancy, storage and path register; reset wins over clk_en.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            path_q  <= 3'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (clk_en) begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        head_q  <= s00_data;
                        state_q <= ONE;
                    end else begin
                        // Only an idle, empty buffer may switch paths.
                        path_q  <= sw;
                    end
                end
                ONE: begin
                    if (acc && del) begin
                        // New word becomes head immediately: no bubble.
                        head_q  <= s00_data;
                    end else if (acc) begin
                        tail_q  <= s00_data;
                        state_q <= FULL;
                    end else if (del) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // acc cannot occur here because ready is low.
                    if (del) begin
                        head_q  <= tail_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Only the active path sees the head word; all others are held at zero.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_out
            assign m_valid[gi] = (state_q != EMPTY) && (path_q == 3'(gi));
            assign m_data[gi]  = m_valid[gi] ? head_q : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/data_pipe_demux.md
DATA_PIPE_DEMUX -- requirements
Module: data_pipe_demux

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, giving the data width of every data_inf port.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port clk_en, input, 1 bit: qualifies every transfer, state change and path update.
REQ-005 The block SHALL have port vld_sw, input, 1 bit: path enable; when 0, upstream acceptance is blocked.
REQ-006 The block SHALL have port sw, input, 3 bits: requested output path.
REQ-007 The block SHALL have port curr_path, output, 3 bits: registered active output path.
REQ-008 The block SHALL have port s00, data_inf.slaver: the single upstream input (valid, ready, data[DSIZE-1:0]).
REQ-009 The block SHALL have ports m00..m07, data_inf.master: the eight downstream outputs.

Function
REQ-010 The block SHALL buffer data in a 2-entry FIFO; state = count of stored words: EMPTY(0), ONE(1), FULL(2).
REQ-011 s00.ready SHALL be combinational: vld_sw AND (state != FULL).
REQ-012 An upstream accept (ACC) SHALL occur only when s00.valid AND s00.ready AND clk_en are all 1.
REQ-013 m[curr_path].valid SHALL be 1 exactly when state != EMPTY, and m[curr_path].data SHALL be the oldest stored word.
REQ-014 Every unselected mNN SHALL drive valid=0 and data=0; every mNN.ready other than m[curr_path].ready SHALL be ignored.
REQ-015 A downstream transfer (DEL) SHALL occur only when m[curr_path].valid AND m[curr_path].ready AND clk_en are all 1.
REQ-016 State transitions SHALL be:
  - ACC only: count+1.
  - DEL only: count-1.
  - ACC and DEL together: count unchanged, order preserved.
  - Neither, or clk_en=0: everything holds.
REQ-017 When DEL and ACC occur together in state ONE, the accepted word SHALL become the head with no bubble cycle.
REQ-018 Latency from ACC to the word appearing on m[curr_path] SHALL be 1 cycle when the FIFO was EMPTY.
REQ-019 Throughput SHALL be 1 word/cycle when downstream ready is held high.
REQ-020 curr_path SHALL load sw only on a cycle with clk_en=1, state=EMPTY and no ACC; otherwise it SHALL hold.
REQ-021 A word accepted SHALL always be delivered on the path that was curr_path at its acceptance, and SHALL never be lost, duplicated or reordered.
REQ-022 A change of sw while the FIFO is non-empty SHALL take effect only after the FIFO drains.
REQ-023 Deasserting vld_sw SHALL drop s00.ready in the same cycle and SHALL NOT stop draining of stored words.
REQ-024 Overflow SHALL be impossible by construction, because ready is 0 when FULL.
REQ-025 m[curr_path].valid, once 1, SHALL stay 1 with stable data until DEL occurs.

Reset
REQ-026 On rst_n=0 at a rising edge, the block SHALL enter state EMPTY, set curr_path=0 and clear the storage to 0.
REQ-027 During and after reset, the block SHALL drive all mNN.valid=0 and all mNN.data=0.
REQ-028 s00.ready SHALL equal vld_sw immediately after reset.
REQ-029 A reset mid-operation SHALL discard all stored words with no output.
REQ-030 Reset SHALL override clk_en.

Verification
REQ-031 Scenario: reset, sw=3, vld_sw=1, clk_en=1, send 0x11 -> curr_path=3 before the accept, m03.valid=1 with data 0x11 one cycle later, all other mNN.valid=0.
REQ-032 Scenario: path 2, m02.ready=0, send 0x21, 0x22, 0x23 -> 0x21 and 0x22 stored, s00.ready=0 while 0x23 is held; after m02.ready=1 the output order is 0x21, 0x22, 0x23.
REQ-033 Scenario: sw changes 2->5 while 2 words are stored on path 2 -> both words exit on m02, and curr_path becomes 5 only in the cycle after EMPTY with no ACC.
REQ-034 Scenario: clk_en toggling 1,0,1,0 with streaming data 0x01..0x08 and ready=1 -> transfers occur only on clk_en=1 cycles, all 8 words arrive in order.
REQ-035 Scenario: vld_sw=0 with 1 word stored -> s00.ready=0 and the stored word still delivers.
REQ-036 Scenario: rst_n=0 asserted with FULL FIFO -> next cycle all mNN.valid=0, curr_path=0, and the stored words never appear.
